// File: rtl/cpu_sequencer.sv
// Instruction-cycle control FSM: walks the 8-state fetch/execute sequence,
// decodes datapath strobes, and adds halt/resume, run gating, single-step and a retire counter.
module cpu_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             run_en,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             resume,
  output logic [2:0]       ps,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t  state;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  assign ps    = 3'(state);
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  // Sequencing: halted hold/resume outranks run/step gating, which outranks normal advance.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= INST_ADDR;
      halted    <= 1'b0;
      step_done <= 1'b0;
      instr_cnt <= '0;
    end else begin
      step_done <= 1'b0;
      case (state)
        INST_ADDR:  if (run_en && (!step_mode || step_req)) state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR: begin
          if (halted) begin
            if (resume) begin
              halted <= 1'b0;
              state  <= OP_FETCH;
            end
          end else if (op == OP_HLT) begin
            halted <= 1'b1;
          end else begin
            state <= OP_FETCH;
          end
        end
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE: begin
          state     <= INST_ADDR;
          step_done <= 1'b1;
          if (instr_cnt != CNT_MAX) instr_cnt <= instr_cnt + CNT_W'(1);
        end
        default:    state <= INST_ADDR;
      endcase
    end
  end

  // Datapath strobes decoded from present state and current instruction.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    case (state)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = !halted;
        halt   = (op == OP_HLT);
      end
      OP_FETCH:   mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == OP_SKZ) && zero;
        load_pc = (op == OP_JMP);
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == OP_JMP);
        load_pc = (op == OP_JMP);
        mem_wr  = (op == OP_STO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: vector table, directed corner sequences and random
// stimulus, all compared against a phase-counting reference model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_, zero, run_en, step_mode, step_req, resume;
  logic [2:0] opcode;
  logic [2:0] ps, ps2;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, halted, step_done;
  logic       mem_rd2, load_ir2, halt2, inc_pc2, load_ac2, load_pc2, mem_wr2, halted2, step_done2;
  logic [15:0] instr_cnt;
  logic [1:0]  instr_cnt2;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .run_en(run_en),
    .step_mode(step_mode), .step_req(step_req), .resume(resume), .ps(ps),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .halted(halted),
    .step_done(step_done), .instr_cnt(instr_cnt)
  );

  cpu_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .run_en(run_en),
    .step_mode(step_mode), .step_req(step_req), .resume(resume), .ps(ps2),
    .mem_rd(mem_rd2), .load_ir(load_ir2), .halt(halt2), .inc_pc(inc_pc2),
    .load_ac(load_ac2), .load_pc(load_pc2), .mem_wr(mem_wr2), .halted(halted2),
    .step_done(step_done2), .instr_cnt(instr_cnt2)
  );

  wire [6:0] stb = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: phase 0..7 within an instruction plus halt flag and retire counts.
  int m_ph = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_h = 0, m_done = 0;
  logic [6:0] smp_stb;
  logic [2:0] smp_ps;

  function automatic logic [6:0] exp_stb(int ph, int op, bit z, bit h);
    bit alu = (op >= 2 && op <= 5);
    logic [6:0] s;
    s[6] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    s[5] = (ph == 2 || ph == 3);
    s[4] = (ph == 4 && op == 0);
    s[3] = (ph == 4 && !h) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    s[2] = (ph == 6 || ph == 7) && alu;
    s[1] = (ph == 6 || ph == 7) && op == 7;
    s[0] = (ph == 7 && op == 6);
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive_sample(input bit r, input int op, input bit z, input bit re,
                              input bit sm, input bit sr, input bit res);
    rst_ = r; opcode = 3'(op); zero = z; run_en = re;
    step_mode = sm; step_req = sr; resume = res;
    @(negedge clk);
    smp_stb = stb;
    smp_ps  = ps;
    if (chk_en) begin
      chk("ps", int'(ps), m_ph);
      chk("strobes", int'(stb), int'(exp_stb(m_ph, op, z, m_h)));
      chk("halted", int'(halted), int'(m_h));
      chk("step_done", int'(step_done), int'(m_done));
      chk("instr_cnt", int'(instr_cnt), m_cnt);
      chk("instr_cnt_w2", int'(instr_cnt2), m_cnt2);
    end
  endtask

  task automatic advance();
    int op = int'(opcode);
    if (!rst_) begin
      m_ph = 0; m_h = 0; m_done = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_done = 0;
      if (m_ph == 4 && m_h) begin
        if (resume) begin m_h = 0; m_ph = 5; end
      end else if (m_ph == 0) begin
        if (run_en && (!step_mode || step_req)) m_ph = 1;
      end else if (m_ph == 4 && op == 0) begin
        m_h = 1;
      end else if (m_ph == 7) begin
        m_ph = 0; m_done = 1;
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end else begin
        m_ph = m_ph + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit r, input int op, input bit z, input bit re,
                     input bit sm, input bit sr, input bit res);
    drive_sample(r, op, z, re, sm, sr, res);
    advance();
  endtask

  // Run one ungated instruction; remembers strobes seen in ALU_OP and STORE.
  logic [6:0] alu_stb, st_stb, oa_stb, of_stb;
  task automatic run_instr(input int op, input bit z);
    for (int k = 0; k < 8; k++) begin
      drive_sample(1, op, z, 1, 0, 0, 0);
      if (k == 4) oa_stb = smp_stb;
      if (k == 5) of_stb = smp_stb;
      if (k == 6) alu_stb = smp_stb;
      if (k == 7) st_stb = smp_stb;
      advance();
    end
  endtask

  typedef struct {
    int         op;
    logic [2:0] eps;
    logic [6:0] estb;
    logic       edone;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // strobe order: mem_rd load_ir halt inc_pc load_ac load_pc mem_wr
    vecs[0]  = '{2, 3'd0, 7'b0000000, 1'b0};
    vecs[1]  = '{2, 3'd1, 7'b1000000, 1'b0};
    vecs[2]  = '{2, 3'd2, 7'b1100000, 1'b0};
    vecs[3]  = '{2, 3'd3, 7'b1100000, 1'b0};
    vecs[4]  = '{2, 3'd4, 7'b0001000, 1'b0};
    vecs[5]  = '{2, 3'd5, 7'b1000000, 1'b0};
    vecs[6]  = '{2, 3'd6, 7'b1000100, 1'b0};
    vecs[7]  = '{2, 3'd7, 7'b1000100, 1'b0};
    vecs[8]  = '{7, 3'd0, 7'b0000000, 1'b1};
    vecs[9]  = '{7, 3'd1, 7'b1000000, 1'b0};
    vecs[10] = '{7, 3'd2, 7'b1100000, 1'b0};
    vecs[11] = '{7, 3'd3, 7'b1100000, 1'b0};
    vecs[12] = '{7, 3'd4, 7'b0001000, 1'b0};
    vecs[13] = '{7, 3'd5, 7'b0000000, 1'b0};
    vecs[14] = '{7, 3'd6, 7'b0000010, 1'b0};
    vecs[15] = '{7, 3'd7, 7'b0001010, 1'b0};
    vecs[16] = '{2, 3'd0, 7'b0000000, 1'b1};

    cyc(0, 2, 0, 0, 0, 0, 0);
    cyc(0, 2, 0, 0, 0, 0, 0);
    chk_en = 1;

    drive_sample(1, 2, 0, 0, 0, 0, 0);
    chk("reset_ps", int'(ps), 0);
    chk("reset_strobes", int'(stb), 0);
    chk("reset_cnt", int'(instr_cnt), 0);
    advance();

    for (int i = 0; i < 17; i++) begin
      drive_sample(1, vecs[i].op, 0, 1, 0, 0, 0);
      chk($sformatf("vec%0d_ps", i), int'(smp_ps), int'(vecs[i].eps));
      chk($sformatf("vec%0d_stb", i), int'(smp_stb), int'(vecs[i].estb));
      chk($sformatf("vec%0d_done", i), int'(step_done), int'(vecs[i].edone));
      advance();
    end
    chk("table_cnt", int'(instr_cnt), 2);

    // Reset asserted mid-instruction in ALU_OP.
    cyc(0, 2, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 2, 0, 1, 0, 0, 0);
    chk("mid_pre_ps", int'(ps), 6);
    cyc(0, 2, 0, 1, 0, 0, 0);
    drive_sample(1, 2, 0, 0, 0, 0, 0);
    chk("mid_ps", int'(ps), 0);
    chk("mid_stb", int'(stb), 0);
    chk("mid_cnt", int'(instr_cnt), 0);
    chk("mid_halted", int'(halted), 0);
    advance();

    run_instr(1, 1);
    chk("skz_z1_inc", int'(alu_stb[3]), 1);
    run_instr(1, 0);
    chk("skz_z0_inc", int'(alu_stb[3]), 0);
    run_instr(7, 0);
    chk("jmp_alu_ldpc", int'(alu_stb[1]), 1);
    chk("jmp_alu_inc", int'(alu_stb[3]), 0);
    chk("jmp_st_both", int'({st_stb[3], st_stb[1]}), 3);
    chk("jmp_oa_of_ldpc", int'({oa_stb[1], of_stb[1]}), 0);
    run_instr(6, 0);
    chk("sto_st_wr", int'(st_stb[0]), 1);
    chk("sto_alu_wr", int'(alu_stb[0]), 0);
    chk("cnt_after4", int'(instr_cnt), 4);

    // HLT: hold in OP_ADDR until resume.
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 0, 0, 0);
    drive_sample(1, 0, 0, 1, 0, 0, 0);
    chk("hlt_first_inc", int'(inc_pc), 1);
    chk("hlt_first_halt", int'(halt), 1);
    advance();
    for (int k = 0; k < 10; k++) begin
      drive_sample(1, 0, 0, 1, 0, 0, 0);
      chk("hlt_hold_ps", int'(ps), 4);
      chk("hlt_hold_inc", int'(inc_pc), 0);
      chk("hlt_hold_halted", int'(halted), 1);
      advance();
    end
    cyc(1, 0, 0, 1, 0, 0, 1);
    chk("hlt_resume_ps", int'(ps), 5);
    chk("hlt_resume_halted", int'(halted), 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, 0, 0, 0);
    chk("hlt_retire_done", int'(step_done), 1);
    chk("hlt_retire_cnt", int'(instr_cnt), 5);

    // Single-step: park, then release exactly one instruction.
    for (int k = 0; k < 20; k++) cyc(1, 2, 0, 1, 1, 0, 0);
    chk("step_park_ps", int'(ps), 0);
    cyc(1, 2, 0, 1, 1, 1, 0);
    for (int k = 0; k < 7; k++) cyc(1, 2, 0, 1, 1, 0, 0);
    chk("step_done_pulse", int'(step_done), 1);
    for (int k = 0; k < 5; k++) cyc(1, 2, 0, 1, 1, 0, 0);
    chk("step_back_ps", int'(ps), 0);
    chk("step_cnt", int'(instr_cnt), 6);

    // Saturation of the 2-bit counter instance.
    cyc(0, 2, 0, 1, 0, 0, 0);
    for (int n = 0; n < 5; n++) run_instr(2, 0);
    chk("sat_cnt2", int'(instr_cnt2), 3);
    chk("sat_cnt16", int'(instr_cnt), 5);

    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 64) != 0, int'($urandom % 8), bit'($urandom % 2),
          ($urandom % 4) != 0, ($urandom % 3) == 0, bit'($urandom % 2),
          ($urandom % 8) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
